// File: rtl/rv_debug_pkg.sv
// rv_debug_pkg: shared debug-path types and constants (dump FSM states, register index type)
package rv_debug_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} dump_state_t;
endpackage

// File: rtl/regfile_dump_reader_if.sv
// regfile_dump_reader_if: dump beat stream (valid/ready, data, index, last); master drives beats, slave drives ready
interface regfile_dump_reader_if
  import rv_debug_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
);
  logic valid;
  logic ready;
  logic last;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] index;
  modport master(output valid, data, index, last, input ready);
  modport slave(input valid, data, index, last, output ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register index range, reads the bank and streams (index, data, last) beats
// ports: clk, rst_n (sync active-low), start/first_reg/last_reg request, rd_addr/rd_data bank read,
//        busy (core stall request), done (pulse after final beat), stream (beat output, master side)
module regfile_dump_reader
  import rv_debug_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NUM_REGS = rv_debug_pkg::NUM_REGS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic busy,
  output logic done,
  regfile_dump_reader_if.master stream
);
  dump_state_t state, state_nx;
  logic [ADDR_W-1:0] idx, end_idx, idx_nx;
  logic fire;
  assign fire = stream.valid && stream.ready;
  // index wraps NUM_REGS-1 -> 0 so a range with last < first walks through the top of the bank
  assign idx_nx = (idx == ADDR_W'(NUM_REGS - 1)) ? '0 : idx + 1'b1;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = (state == IDLE)  ? (start ? FETCH : IDLE) :
               (state == FETCH) ? SEND :
               (state == SEND)  ? (fire ? (stream.last ? DONE : FETCH) : SEND) :
                                  IDLE;
    busy = (state == FETCH) || (state == SEND);
    done = (state == DONE);
    rd_addr = busy ? idx : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
      end_idx <= '0;
      stream.valid <= 1'b0;
      stream.data <= '0;
      stream.index <= '0;
      stream.last <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        idx <= first_reg;
        end_idx <= last_reg;
      end
      if (state == FETCH) begin
        stream.data <= rd_data;
        stream.index <= idx;
        stream.last <= (idx == end_idx);
        stream.valid <= 1'b1;
      end
      if (state == SEND && fire) begin
        stream.valid <= 1'b0;
        if (!stream.last) idx <= idx_nx;
      end
    end
  end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: scoreboard bench for regfile_dump_reader with a modelled register bank
module tb_regfile_dump_reader;
  import rv_debug_pkg::*;
  typedef struct packed {
    logic [4:0] index;
    logic [31:0] data;
    logic last;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  reg_idx_t first_reg = '0;
  reg_idx_t last_reg = '0;
  reg_idx_t rd_addr;
  logic [31:0] rd_data;
  logic busy, done;
  logic [31:0] bank [32];
  beat_t sb[$];
  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  int stall_left = 0;
  logic prev_stall = 1'b0;
  beat_t prev_beat;
  regfile_dump_reader_if #(.DATA_W(32), .ADDR_W(5)) stream();
  regfile_dump_reader #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .first_reg(first_reg),
    .last_reg(last_reg),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy(busy),
    .done(done),
    .stream(stream)
  );
  assign rd_data = bank[rd_addr];
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // consumer: mode 0 always ready, 1 random with a forced 5-cycle stall on index 3, 3 refuses index 10
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1 && stream.valid && stream.index == 5'd3 && stall_left > 0) begin
      stream.ready = 1'b0;
      stall_left--;
    end else if (ready_mode == 3) stream.ready = !(stream.valid && stream.index == 5'd10);
    else if (ready_mode == 1) stream.ready = 1'($urandom_range(0, 1));
    else stream.ready = 1'b1;
  end
  always @(negedge clk) begin
    beat_t cur, exp_b;
    cur = {stream.index, stream.data, stream.last};
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("hold_valid", 64'(stream.valid), 64'd1);
        check("hold_beat", 64'(cur), 64'(prev_beat));
      end
      if (stream.valid && stream.ready) begin
        if (sb.size() == 0) check("beat_expected", 64'(sb.size()), 64'd1);
        else begin
          exp_b = sb.pop_front();
          check("beat", 64'(cur), 64'(exp_b));
        end
      end
      prev_stall = stream.valid && !stream.ready;
      prev_beat = cur;
    end
  end
  task automatic push_range(input reg_idx_t f, input reg_idx_t l);
    int n;
    reg_idx_t i;
    n = int'(5'(l - f)) + 1;
    for (int k = 0; k < n; k++) begin
      i = 5'(int'(f) + k);
      sb.push_back({i, bank[i], k == n - 1});
    end
  endtask
  task automatic run_dump(input reg_idx_t f, input reg_idx_t l, input bit extra, input bit full);
    int bcnt;
    bit got_done;
    push_range(f, l);
    @(posedge clk);
    #1;
    first_reg = f;
    last_reg = l;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    first_reg = ~f;
    last_reg = ~l;
    bcnt = 0;
    got_done = 1'b0;
    for (int c = 0; c < 1000 && !got_done; c++) begin
      if (c == 0) check("lat_valid_low", 64'(stream.valid), 64'd0);
      if (c == 1) check("lat_valid_high", 64'(stream.valid), 64'd1);
      if (busy) bcnt++;
      if (done) got_done = 1'b1;
      else begin
        if (extra && c == 8) begin
          first_reg = 5'd20;
          last_reg = 5'd25;
          start = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    check("done_seen", 64'(got_done), 64'd1);
    check("done_not_busy", 64'(busy), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    if (full) check("busy_cycles", 64'(bcnt), 64'd64);
    @(posedge clk);
    #1;
    check("done_pulse_end", 64'(done), 64'd0);
    check("idle_valid", 64'(stream.valid), 64'd0);
    check("idle_rd_addr", 64'(rd_addr), 64'd0);
  endtask
  initial begin
    bit hit;
    for (int i = 0; i < 32; i++) bank[i] = 32'h1000_0000 | 32'(i);
    bank[0] = 32'd0;
    bank[2] = 32'd1024;
    bank[5] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(stream.valid), 64'd0);
    check("rst_beat", 64'({stream.index, stream.data, stream.last}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    rst_n = 1'b1;
    run_dump(5'd0, 5'd31, 1'b0, 1'b1);
    run_dump(5'd7, 5'd7, 1'b0, 1'b0);
    run_dump(5'd30, 5'd1, 1'b0, 1'b0);
    ready_mode = 1;
    stall_left = 5;
    run_dump(5'd0, 5'd8, 1'b1, 1'b0);
    check("stall_used", 64'(stall_left), 64'd0);
    ready_mode = 3;
    push_range(5'd5, 5'd20);
    @(posedge clk);
    #1;
    first_reg = 5'd5;
    last_reg = 5'd20;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(posedge clk);
      #2;
      hit = stream.valid && stream.index == 5'd10 && !stream.ready;
    end
    check("reached_idx10", 64'(hit), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    check("abort_valid", 64'(stream.valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_rd_addr", 64'(rd_addr), 64'd0);
    ready_mode = 0;
    run_dump(5'd0, 5'd2, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
